neuron_array: RTL and testbench

NEURON_ARRAY -- requirements
Module: neuron_array

---
 rtl/neuron_array.sv | 115 +++++++++++
 tb/tb_neuron_array.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_array.sv
// Time-multiplexed leaky integrate-and-fire array: one channel updated per enabled cycle.
// Spikes reach the output FIFO head one cycle after the update; a full FIFO drops spikes and sets sticky spk_ovf.
module neuron_array #(
  parameter int N_CH       = 4,
  parameter int V_W        = 16,
  parameter int I_W        = 16,
  parameter int V_REST     = 0,
  parameter int V_RESET    = 0,
  parameter int V_TH       = 1000,
  parameter int LEAK_SHIFT = 4,
  parameter int EXP_EN     = 0,
  parameter int V_T        = 800,
  parameter int EXP_SHIFT  = 2,
  parameter int REF_CYC    = 2,
  parameter int SPK_DEPTH  = 4,
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  i_wr_valid,
  input  logic [PW-1:0]         i_wr_ch,
  input  logic signed [I_W-1:0] i_wr_data,
  output logic                  i_wr_ready,
  output logic                  spike_valid,
  output logic [PW-1:0]         spike_ch,
  input  logic                  spike_ready,
  output logic                  spk_ovf,
  input  logic [PW-1:0]         v_rd_ch,
  output logic signed [V_W-1:0] v_rd_data
);
  localparam int EW = ((V_W > I_W) ? V_W : I_W) + 2;
  localparam int RW = (REF_CYC > 0) ? $clog2(REF_CYC + 1) : 1;
  localparam int AW = (SPK_DEPTH > 1) ? $clog2(SPK_DEPTH) : 1;
  localparam logic signed [EW-1:0] VMAX = {{(EW-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
  localparam logic signed [EW-1:0] VMIN = {{(EW-V_W+1){1'b1}}, {(V_W-1){1'b0}}};

  logic signed [V_W-1:0] v   [N_CH];
  logic signed [I_W-1:0] cur [N_CH];
  logic [RW-1:0]         refr [N_CH];
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         mem [2**AW];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           cnt;
  logic                  ovf;

  logic signed [EW-1:0] v_e, i_e, leak, knee, sum, sat;
  logic fire, full, empty, pop, push, drop;

  always_comb begin
    v_e  = EW'(v[ptr]);
    i_e  = EW'(cur[ptr]);
    leak = (v_e - EW'(V_REST)) >>> LEAK_SHIFT;
    knee = '0;
    if (EXP_EN != 0 && v_e > EW'(V_T))
      knee = (v_e - EW'(V_T)) >>> EXP_SHIFT;
    sum = v_e + i_e - leak + knee;
    sat = sum;
    if (sum > VMAX) sat = VMAX;
    else if (sum < VMIN) sat = VMIN;
  end

  assign fire  = en && (refr[ptr] == '0) && (sat >= EW'(V_TH));
  assign full  = (cnt == (AW+1)'(SPK_DEPTH));
  assign empty = (cnt == '0);
  assign pop   = !empty && spike_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = fire && (!full || pop);
  assign drop  = fire && full && !pop;

  assign i_wr_ready  = 1'b1;
  assign spike_valid = !empty;
  assign spike_ch    = empty ? '0 : mem[rd_ptr];
  assign spk_ovf     = ovf;
  assign v_rd_data   = v[v_rd_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        v[i]    <= V_W'(V_REST);
        cur[i]  <= '0;
        refr[i] <= '0;
      end
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      // The update below reads cur[ptr] combinationally, so a colliding write lands after it.
      if (i_wr_valid) cur[i_wr_ch] <= i_wr_data;
      if (en) begin
        if (refr[ptr] != '0) begin
          v[ptr]    <= V_W'(V_RESET);
          refr[ptr] <= refr[ptr] - 1'b1;
        end else if (fire) begin
          v[ptr]    <= V_W'(V_RESET);
          refr[ptr] <= RW'(REF_CYC);
        end else begin
          v[ptr] <= sat[V_W-1:0];
        end
        ptr <= (ptr == PW'(N_CH - 1)) ? '0 : ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= ptr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_neuron_array.sv
// Directed bench: instance a (LEAK_SHIFT=15) and instance b (LEAK_SHIFT=15, EXP_EN=1).
module tb_neuron_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic spike_ready = 1'b0;

  logic i_wr_valid = 1'b0;
  logic [1:0] i_wr_ch = '0;
  logic signed [15:0] i_wr_data = '0;
  logic i_wr_ready, spike_valid, spk_ovf;
  logic [1:0] spike_ch;
  logic [1:0] v_rd_ch = '0;
  logic signed [15:0] v_rd_data;

  logic i_wr_valid_b = 1'b0;
  logic [1:0] i_wr_ch_b = '0;
  logic signed [15:0] i_wr_data_b = '0;
  logic i_wr_ready_b, spike_valid_b, spk_ovf_b;
  logic [1:0] spike_ch_b;
  logic [1:0] v_rd_ch_b = '0;
  logic signed [15:0] v_rd_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_array #(.LEAK_SHIFT(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i_wr_valid(i_wr_valid), .i_wr_ch(i_wr_ch), .i_wr_data(i_wr_data), .i_wr_ready(i_wr_ready),
    .spike_valid(spike_valid), .spike_ch(spike_ch), .spike_ready(spike_ready),
    .spk_ovf(spk_ovf), .v_rd_ch(v_rd_ch), .v_rd_data(v_rd_data)
  );

  neuron_array #(.LEAK_SHIFT(15), .EXP_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i_wr_valid(i_wr_valid_b), .i_wr_ch(i_wr_ch_b), .i_wr_data(i_wr_data_b), .i_wr_ready(i_wr_ready_b),
    .spike_valid(spike_valid_b), .spike_ch(spike_ch_b), .spike_ready(spike_ready),
    .spk_ovf(spk_ovf_b), .v_rd_ch(v_rd_ch_b), .v_rd_data(v_rd_data_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int n);
    en = 1'b1;
    repeat (4 * n) step();
    en = 1'b0;
  endtask

  task automatic wr_a(input logic [1:0] ch, input logic signed [15:0] d);
    i_wr_valid = 1'b1; i_wr_ch = ch; i_wr_data = d;
    step();
    i_wr_valid = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] ch, input logic signed [15:0] d);
    i_wr_valid_b = 1'b1; i_wr_ch_b = ch; i_wr_data_b = d;
    step();
    i_wr_valid_b = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; spike_ready = 1'b0; i_wr_valid = 1'b0; i_wr_valid_b = 1'b0;
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (spike_valid !== 1'b0) begin errors++; $display("FAIL reset_in_spike_valid got %0b want 0", spike_valid); end
    #11 rst_n = 1'b1;
    step();
    checks++;
    if (spike_valid !== 1'b0 || spk_ovf !== 1'b0 || spike_ch !== 2'd0) begin
      errors++; $display("FAIL reset_flags got valid=%0b ovf=%0b ch=%0d want 0 0 0", spike_valid, spk_ovf, spike_ch);
    end
    checks++;
    if (i_wr_ready !== 1'b1 || i_wr_ready_b !== 1'b1) begin
      errors++; $display("FAIL wr_ready got %0b/%0b want 1", i_wr_ready, i_wr_ready_b);
    end
    for (int c = 0; c < 4; c++) begin
      v_rd_ch = 2'(c);
      #1;
      checks++;
      if (v_rd_data !== 16'sd0) begin errors++; $display("FAIL reset_v ch%0d got %0d want 0", c, v_rd_data); end
    end
  endtask

  task automatic test_integrate();
    int exp_v [3];
    exp_v = '{250, 500, 750};
    do_reset();
    wr_a(2'd0, 16'sd250);
    v_rd_ch = 2'd0;
    for (int s = 0; s < 3; s++) begin
      sweep(1);
      checks++;
      if (v_rd_data !== 16'(exp_v[s]) || spike_valid !== 1'b0) begin
        errors++; $display("FAIL integ_sweep%0d got v=%0d valid=%0b want %0d 0", s + 1, v_rd_data, spike_valid, exp_v[s]);
      end
    end
    sweep(1);
    checks++;
    if (v_rd_data !== 16'sd0 || spike_valid !== 1'b1 || spike_ch !== 2'd0) begin
      errors++; $display("FAIL integ_spike got v=%0d valid=%0b ch=%0d want 0 1 0", v_rd_data, spike_valid, spike_ch);
    end
    spike_ready = 1'b1;
    step();
    spike_ready = 1'b0;
    checks++;
    if (spike_valid !== 1'b0) begin errors++; $display("FAIL integ_pop got valid=%0b want 0", spike_valid); end
    for (int s = 5; s <= 6; s++) begin
      sweep(1);
      checks++;
      if (v_rd_data !== 16'sd0) begin errors++; $display("FAIL integ_refr_sweep%0d got %0d want 0", s, v_rd_data); end
    end
    sweep(1);
    checks++;
    if (v_rd_data !== 16'sd250) begin errors++; $display("FAIL integ_resume got %0d want 250", v_rd_data); end
  endtask

  task automatic test_saturation();
    do_reset();
    wr_a(2'd1, 16'sh8000);
    v_rd_ch = 2'd1;
    for (int s = 1; s <= 3; s++) begin
      sweep(1);
      checks++;
      if (v_rd_data !== 16'sh8000 || spike_valid !== 1'b0) begin
        errors++; $display("FAIL sat_sweep%0d got v=%0d valid=%0b want -32768 0", s, v_rd_data, spike_valid);
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    wr_a(2'd2, 16'sd100);
    v_rd_ch = 2'd2;
    sweep(1);
    checks++;
    if (v_rd_data !== 16'sd100) begin errors++; $display("FAIL coll_pre got %0d want 100", v_rd_data); end
    en = 1'b1;
    step(); step();
    i_wr_valid = 1'b1; i_wr_ch = 2'd2; i_wr_data = 16'sd300;
    step();
    i_wr_valid = 1'b0;
    step();
    en = 1'b0;
    checks++;
    if (v_rd_data !== 16'sd200) begin errors++; $display("FAIL coll_old_i got %0d want 200", v_rd_data); end
    sweep(1);
    checks++;
    if (v_rd_data !== 16'sd500) begin errors++; $display("FAIL coll_new_i got %0d want 500", v_rd_data); end
  endtask

  task automatic test_exp();
    do_reset();
    wr_b(2'd3, 16'sd300);
    v_rd_ch_b = 2'd3;
    sweep(3);
    checks++;
    if (v_rd_data_b !== 16'sd900) begin errors++; $display("FAIL exp_below_knee got %0d want 900", v_rd_data_b); end
    wr_b(2'd3, 16'sd0);
    sweep(1);
    checks++;
    if (v_rd_data_b !== 16'sd925) begin errors++; $display("FAIL exp_k25 got %0d want 925", v_rd_data_b); end
    sweep(1);
    checks++;
    if (v_rd_data_b !== 16'sd956) begin errors++; $display("FAIL exp_k31 got %0d want 956", v_rd_data_b); end
    checks++;
    if (spike_valid_b !== 1'b0 || spk_ovf_b !== 1'b0 || spike_ch_b !== 2'd0) begin
      errors++; $display("FAIL exp_nospike got valid=%0b ovf=%0b ch=%0d want 0 0 0", spike_valid_b, spk_ovf_b, spike_ch_b);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 4; c++) wr_a(2'(c), 16'sd1000);
    v_rd_ch = 2'd0;
    sweep(1);
    checks++;
    if (spike_valid !== 1'b1 || spike_ch !== 2'd0 || spk_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_fill got valid=%0b ch=%0d ovf=%0b want 1 0 0", spike_valid, spike_ch, spk_ovf);
    end
    sweep(2);
    checks++;
    if (spk_ovf !== 1'b0 || spike_ch !== 2'd0) begin
      errors++; $display("FAIL ovf_refr got ovf=%0b ch=%0d want 0 0", spk_ovf, spike_ch);
    end
    sweep(1);
    checks++;
    if (spk_ovf !== 1'b1 || v_rd_data !== 16'sd0) begin
      errors++; $display("FAIL ovf_drop got ovf=%0b v0=%0d want 1 0", spk_ovf, v_rd_data);
    end
    spike_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (spike_valid !== 1'b1 || spike_ch !== 2'(k)) begin
        errors++; $display("FAIL drain%0d got valid=%0b ch=%0d want 1 %0d", k, spike_valid, spike_ch, k);
      end
      step();
    end
    spike_ready = 1'b0;
    checks++;
    if (spike_valid !== 1'b0 || spk_ovf !== 1'b1) begin
      errors++; $display("FAIL drain_empty got valid=%0b ovf=%0b want 0 1", spike_valid, spk_ovf);
    end
  endtask

  task automatic test_async_reset();
    wr_a(2'd2, 16'sd300);
    wr_a(2'd3, 16'sd300);
    sweep(3);
    en = 1'b1;
    step();
    en = 1'b0;
    v_rd_ch = 2'd2;
    #1;
    checks++;
    if (v_rd_data !== 16'sd300 || spike_valid !== 1'b1 || spk_ovf !== 1'b1) begin
      errors++; $display("FAIL arst_pre got v2=%0d valid=%0b ovf=%0b want 300 1 1", v_rd_data, spike_valid, spk_ovf);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (spike_valid !== 1'b0 || spike_ch !== 2'd0 || spk_ovf !== 1'b0 || v_rd_data !== 16'sd0) begin
      errors++; $display("FAIL arst_clear got valid=%0b ch=%0d ovf=%0b v2=%0d want 0 0 0 0", spike_valid, spike_ch, spk_ovf, v_rd_data);
    end
    #3 rst_n = 1'b1;
    wr_a(2'd0, 16'sd7);
    wr_a(2'd1, 16'sd7);
    en = 1'b1;
    step();
    en = 1'b0;
    v_rd_ch = 2'd0;
    #1;
    checks++;
    if (v_rd_data !== 16'sd7) begin errors++; $display("FAIL arst_restart_ch0 got %0d want 7", v_rd_data); end
    v_rd_ch = 2'd1;
    #1;
    checks++;
    if (v_rd_data !== 16'sd0) begin errors++; $display("FAIL arst_ch1_idle got %0d want 0", v_rd_data); end
    en = 1'b1;
    step();
    en = 1'b0;
    checks++;
    if (v_rd_data !== 16'sd7) begin errors++; $display("FAIL arst_next_ch1 got %0d want 7", v_rd_data); end
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_saturation();
    test_collision();
    test_exp();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
